// File: rtl/exe_stage.sv
// Execute stage: operand-2 shifter, ALU with NZCV flags, branch target adder,
// status register and EXE->MEM pipeline register.
// Optional operand forwarding is compiled in when FORWARDING_EN is defined.
module exe_stage #(
    parameter logic [3:0] SR_INIT = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        B,
    input  logic        S,
    input  logic [3:0]  EXE_CMD,
    input  logic        imm,
    input  logic [31:0] PC,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic [11:0] Shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  Dest,
`ifdef FORWARDING_EN
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] MEM_ALU_res,
    input  logic [31:0] WB_Value,
`endif
    output logic        Branch_taken,
    output logic [31:0] Br_addr,
    output logic [3:0]  SR,
    output logic        WB_EN_OUT,
    output logic        MEM_R_EN_OUT,
    output logic        MEM_W_EN_OUT,
    output logic [31:0] ALU_res,
    output logic [31:0] Val_Rm_OUT,
    output logic [3:0]  Dest_OUT
);

    logic [31:0] rn_val, rm_val, val2, res, op_b;
    logic [32:0] sum;
    logic [63:0] rot;
    logic [3:0]  flags_d, sr_q;
    logic        arith, known;

    logic        wb_en_q, mem_r_en_q, mem_w_en_q;
    logic [31:0] alu_res_q, val_rm_q;
    logic [3:0]  dest_q;

`ifdef FORWARDING_EN
    // Operand source selection; the unused code 11 falls back to the register value.
    always_comb begin
        rn_val = Val_Rn;
        rm_val = Val_Rm;
        case (sel_src1)
            2'b01:   rn_val = MEM_ALU_res;
            2'b10:   rn_val = WB_Value;
            default: rn_val = Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   rm_val = MEM_ALU_res;
            2'b10:   rm_val = WB_Value;
            default: rm_val = Val_Rm;
        endcase
    end
`else
    assign rn_val = Val_Rn;
    assign rm_val = Val_Rm;
`endif

    // Operand 2: memory offset, rotated immediate, or shifted register.
    // Rotates use a doubled word so an amount of 0 naturally passes through.
    always_comb begin
        val2 = rm_val;
        rot  = '0;
        if (MEM_R_EN || MEM_W_EN) begin
            val2 = {20'b0, Shift_operand};
        end else if (imm) begin
            rot  = {24'b0, Shift_operand[7:0], 24'b0, Shift_operand[7:0]} >> {Shift_operand[11:8], 1'b0};
            val2 = rot[31:0];
        end else begin
            case (Shift_operand[6:5])
                2'b00: val2 = rm_val << Shift_operand[11:7];
                2'b01: val2 = rm_val >> Shift_operand[11:7];
                2'b10: val2 = 32'($signed(rm_val) >>> Shift_operand[11:7]);
                default: begin
                    rot  = {rm_val, rm_val} >> Shift_operand[11:7];
                    val2 = rot[31:0];
                end
            endcase
        end
    end

    // ALU. Subtraction is done as Rn + ~Val2 + carry so C is "not borrow"
    // and one overflow rule covers every arithmetic op. Carry-in comes from SR.
    always_comb begin
        res     = '0;
        sum     = '0;
        op_b    = val2;
        arith   = 1'b0;
        known   = 1'b1;
        flags_d = sr_q;
        case (EXE_CMD)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010: begin arith = 1'b1; sum = {1'b0, rn_val} + {1'b0, op_b}; end
            4'b0011: begin arith = 1'b1; sum = {1'b0, rn_val} + {1'b0, op_b} + {32'b0, sr_q[1]}; end
            4'b0100: begin arith = 1'b1; op_b = ~val2; sum = {1'b0, rn_val} + {1'b0, op_b} + 33'd1; end
            4'b0101: begin arith = 1'b1; op_b = ~val2; sum = {1'b0, rn_val} + {1'b0, op_b} + {32'b0, sr_q[1]}; end
            4'b0110: res = rn_val & val2;
            4'b0111: res = rn_val | val2;
            4'b1000: res = rn_val ^ val2;
            default: known = 1'b0;
        endcase
        if (arith) begin
            res        = sum[31:0];
            flags_d[1] = sum[32];
            flags_d[0] = (rn_val[31] == op_b[31]) && (res[31] != rn_val[31]);
        end
        if (known) begin
            flags_d[3] = res[31];
            flags_d[2] = (res == 32'd0);
        end
    end

    assign Branch_taken = B;
    assign Br_addr      = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

    // Status register: reset wins, then freeze, then S.
    always_ff @(posedge clk) begin
        if (rst)
            sr_q <= SR_INIT;
        else if (S && !freeze)
            sr_q <= flags_d;
    end

    // EXE->MEM pipeline register; reset clears it even while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
        end else if (!freeze) begin
            wb_en_q    <= WB_EN;
            mem_r_en_q <= MEM_R_EN;
            mem_w_en_q <= MEM_W_EN;
            alu_res_q  <= res;
            val_rm_q   <= rm_val;
            dest_q     <= Dest;
        end
    end

    assign SR           = sr_q;
    assign WB_EN_OUT    = wb_en_q;
    assign MEM_R_EN_OUT = mem_r_en_q;
    assign MEM_W_EN_OUT = mem_w_en_q;
    assign ALU_res      = alu_res_q;
    assign Val_Rm_OUT   = val_rm_q;
    assign Dest_OUT     = dest_q;

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter SR_INIT, default 4'b0000, giving the status register value after reset as {N,Z,C,V}.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port freeze  input  1  when high, holds the status register and the output register.
REQ-005 SHALL have ports WB_EN, MEM_R_EN, MEM_W_EN, B, S  input  1 each  decoded controls from the ID pipeline register.
REQ-006 SHALL have ports EXE_CMD  input  4  ALU opcode; imm  input  1  operand-2 immediate select.
REQ-007 SHALL have ports PC, Val_Rn, Val_Rm  input  32 each; Shift_operand  input  12; Signed_imm_24  input  24; Dest  input  4.
REQ-008 SHALL have ports Branch_taken  output  1 and Br_addr  output  32  combinational branch signals to IF.
REQ-009 SHALL have port SR  output  4  registered {N,Z,C,V} to the ID condition check.
REQ-010 SHALL have ports WB_EN_OUT, MEM_R_EN_OUT, MEM_W_EN_OUT  output  1 each; ALU_res, Val_Rm_OUT  output  32 each; Dest_OUT  output  4  registered outputs to MEM.

Function
REQ-011 SHALL compute Val2 from Shift_operand by the first matching rule below.
- MEM_R_EN or MEM_W_EN: zero-extended Shift_operand[11:0].
- imm=1: {24'b0,Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
- Otherwise: Val_Rm shifted by Shift_operand[11:7] with type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-012 SHALL treat a shift or rotate amount of 0 as no shift for every type.
REQ-013 SHALL implement EXE_CMD as follows; any other code SHALL give result 0 and leave flags unchanged.
- 0001 MOV=Val2; 1001 MVN=~Val2.
- 0010 ADD=Rn+Val2; 0011 ADC=Rn+Val2+C.
- 0100 SUB=Rn-Val2; 0101 SBC=Rn-Val2-~C.
- 0110 AND; 0111 ORR; 1000 EOR.
REQ-014 SHALL take C for ADC/SBC from the registered SR, not from the current result.
REQ-015 SHALL compute flags as follows:
- N = result[31]; Z = (result==0).
- C = carry-out of the 33-bit add, or NOT borrow for SUB/SBC; logic/move ops keep C.
- V = signed overflow for arithmetic ops; logic/move ops keep V.
REQ-016 SHALL load SR with the new flags on a rising edge when S=1 and freeze=0; otherwise SR holds.
REQ-017 SHALL drive Br_addr = PC + (sign-extended Signed_imm_24 << 2), modulo 2^32, and Branch_taken = B, both combinationally.
REQ-018 SHALL register WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, Val_Rm and Dest into the *_OUT ports with one-cycle latency when freeze=0.
REQ-019 SHALL give freeze priority over S for SR updates and over new data for the output register.
REQ-020 SHALL wrap arithmetic modulo 2^32; 0xFFFFFFFF+1 gives 0 with Z=1, C=1, V=0.

Reset
REQ-021 SHALL, on a rising edge with rst=1 and regardless of freeze, set SR=SR_INIT and clear all *_OUT registers to 0.
REQ-022 SHALL abort any in-flight result when rst is asserted mid-stream; no value issued before reset SHALL appear after it.

Configuration
REQ-023 SHALL compile forwarding logic in when FORWARDING_EN is defined.
- Adds inputs sel_src1 and sel_src2 (2 bits each), plus MEM_ALU_res and WB_Value (32 bits each).
- Select 00 = register value, 01 = MEM_ALU_res, 10 = WB_Value.
- src1 selects the Rn operand; src2 selects the Rm operand used for both Val2 and Val_Rm_OUT.
REQ-024 SHALL, without FORWARDING_EN, omit these ports and use Val_Rn and Val_Rm directly.

Verification
REQ-025 SHALL cover: SR=0000, ADD S=1 with Rn=0x7FFFFFFF, Val2=1 -> ALU_res 0x80000000, SR 1001 next cycle.
REQ-026 SHALL cover: imm=1, Shift_operand=0x4FF, MOV -> ALU_res 0xFF000000.
REQ-027 SHALL cover: Val_Rm=0x80000000, ASR #4 (Shift_operand=0x240), MOV -> 0xF8000000.
REQ-028 SHALL cover: B=1, PC=0x100, Signed_imm_24=0xFFFFFE -> Branch_taken=1, Br_addr 0xF8.
REQ-029 SHALL cover: freeze=1 during SUB S=1 -> SR and *_OUT unchanged; rst=1 with freeze=1 -> SR=SR_INIT, outputs 0.
REQ-030 SHALL cover: with FORWARDING_EN, sel_src1=01, MEM_ALU_res=5, ADD Val2=3 -> ALU_res 8.
